// File: rtl/filt3x3_sched.sv
// Raster-order sequencer feeding a 3x3 RGB444 window to a filter and writing its result back.
// Per pixel: 10 fetch + FILT_LAT wait + 1 write cycles; no backpressure, memories respond in fixed time.
module filt3x3_sched #(
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int ADDR_W   = 15,
    parameter int FILT_LAT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_rd,
    input  logic [11:0]       src_data,
    output logic [107:0]      color_data,
    input  logic [11:0]       filter_rgb,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [11:0]       dst_data,
    output logic              dst_we,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(FILT_LAT + 10);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] XMAX = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] YMAX = ADDR_W'(IMG_H - 1);
    localparam logic [CW-1:0] FETCH_LAST = CW'(9);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(FILT_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] x_q, x_d, y_q, y_d, row_q, row_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [8:0][11:0]  window_q, window_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d, dst_addr_q, dst_addr_d;
    logic [11:0]       dst_data_q, dst_data_d;
    logic              src_rd_q, src_rd_d, dst_we_q, dst_we_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [3:0]        slot;

    // Neighbour address for window slot k, clamped to the frame edges.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] x,
                                                    input logic [ADDR_W-1:0] y,
                                                    input logic [ADDR_W-1:0] row,
                                                    input logic [3:0] k);
        logic [ADDR_W-1:0] xl, xr, ru, rd, r, c;
        xl = (x == '0)   ? x   : x - ONE;
        xr = (x == XMAX) ? x   : x + ONE;
        ru = (y == '0)   ? row : row - W_A;
        rd = (y == YMAX) ? row : row + W_A;
        case (k)
            4'd1:    begin r = row; c = xl; end
            4'd2:    begin r = row; c = xr; end
            4'd3:    begin r = ru;  c = x;  end
            4'd4:    begin r = rd;  c = x;  end
            4'd5:    begin r = ru;  c = xl; end
            4'd6:    begin r = ru;  c = xr; end
            4'd7:    begin r = rd;  c = xl; end
            4'd8:    begin r = rd;  c = xr; end
            default: begin r = row; c = x;  end
        endcase
        return r + c;
    endfunction

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        window_d   = window_q;
        src_addr_d = '0;
        src_rd_d   = 1'b0;
        dst_addr_d = '0;
        dst_data_d = '0;
        dst_we_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        slot       = 4'(cnt_q) - 4'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FETCH;
                    x_d      = '0;
                    y_d      = '0;
                    row_d    = '0;
                    cnt_d    = '0;
                    src_rd_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_FETCH: begin
                busy_d = 1'b1;
                // Read data trails its strobe by one cycle, so capture lags the issue slot.
                if (cnt_q != '0) window_d[4'd8 - slot] = src_data;
                if (cnt_q == FETCH_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q < CW'(8)) begin
                        src_rd_d   = 1'b1;
                        src_addr_d = slot_addr(x_q, y_q, row_q, 4'(cnt_d));
                    end
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == WAIT_LAST) begin
                    state_d    = S_WRITE;
                    dst_we_d   = 1'b1;
                    dst_addr_d = row_q + x_q;
                    dst_data_d = filter_rgb;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WRITE: begin
                if (x_q == XMAX && y_q == YMAX) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (x_q == XMAX) begin
                        x_d   = '0;
                        y_d   = y_q + ONE;
                        row_d = row_q + W_A;
                    end else begin
                        x_d = x_q + ONE;
                    end
                    state_d    = S_FETCH;
                    cnt_d      = '0;
                    src_rd_d   = 1'b1;
                    src_addr_d = row_d + x_d;
                    busy_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            window_q   <= '0;
            src_addr_q <= '0;
            src_rd_q   <= 1'b0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
            dst_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            window_q   <= window_d;
            src_addr_q <= src_addr_d;
            src_rd_q   <= src_rd_d;
            dst_addr_q <= dst_addr_d;
            dst_data_q <= dst_data_d;
            dst_we_q   <= dst_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign src_addr   = src_addr_q;
    assign src_rd     = src_rd_q;
    assign color_data = window_q;
    assign dst_addr   = dst_addr_q;
    assign dst_data   = dst_data_q;
    assign dst_we     = dst_we_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_filt3x3_sched.sv
// Bench for filt3x3_sched: a 4x3 frame with a 4-cycle filter and a 2x2 frame with a 1-cycle filter.
module tb_filt3x3_sched;
    localparam int AW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int mode = 0;  // 0: pass-through of centre, 1: inverted centre

    logic          rst_a, start_a, a_src_rd, a_dst_we, a_busy, a_done;
    logic [AW-1:0] a_src_addr, a_dst_addr;
    logic [11:0]   a_src_data = '0, a_filt, a_dst_data;
    logic [107:0]  a_color;
    logic          rst_b, start_b, b_src_rd, b_dst_we, b_busy, b_done;
    logic [AW-1:0] b_src_addr, b_dst_addr;
    logic [11:0]   b_src_data = '0, b_filt, b_dst_data;
    logic [107:0]  b_color;

    logic [11:0] mem_a [12];
    logic [11:0] dst_a [12];
    logic [11:0] mem_b [4];
    logic [11:0] dst_b [4];
    logic [11:0] pa [3];
    int a_rd_log [108];

    filt3x3_sched #(.IMG_W(4), .IMG_H(3), .ADDR_W(AW), .FILT_LAT(4)) dut_a (
        .clk(clk), .reset_n(rst_a), .start(start_a), .src_addr(a_src_addr), .src_rd(a_src_rd),
        .src_data(a_src_data), .color_data(a_color), .filter_rgb(a_filt), .dst_addr(a_dst_addr),
        .dst_data(a_dst_data), .dst_we(a_dst_we), .busy(a_busy), .done(a_done));

    filt3x3_sched #(.IMG_W(2), .IMG_H(2), .ADDR_W(AW), .FILT_LAT(1)) dut_b (
        .clk(clk), .reset_n(rst_b), .start(start_b), .src_addr(b_src_addr), .src_rd(b_src_rd),
        .src_data(b_src_data), .color_data(b_color), .filter_rgb(b_filt), .dst_addr(b_dst_addr),
        .dst_data(b_dst_data), .dst_we(b_dst_we), .busy(b_busy), .done(b_done));

    function automatic logic [11:0] filt(input logic [107:0] w);
        return (mode == 1) ? ~w[107:96] : w[107:96];
    endfunction

    // Memories answer one cycle after the strobe; filter A is a 4-cycle pipe, filter B is 1-cycle.
    always @(posedge clk) begin
        if (a_src_rd) a_src_data <= mem_a[a_src_addr[3:0]];
        if (b_src_rd) b_src_data <= mem_b[b_src_addr[1:0]];
        pa[0] <= filt(a_color);
        pa[1] <= pa[0];
        pa[2] <= pa[1];
    end
    assign a_filt = pa[2];
    assign b_filt = filt(b_color);

    task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Address of neighbour k of raster pixel p, from clamped coordinates.
    function automatic int exp_addr(input int w, input int h, input int p, input int k);
        int x, y;
        x = p % w + ((k inside {1, 5, 7}) ? -1 : (k inside {2, 6, 8}) ? 1 : 0);
        y = p / w + ((k inside {3, 5, 6}) ? -1 : (k inside {4, 7, 8}) ? 1 : 0);
        if (x < 0) x = 0;
        if (x > w - 1) x = w - 1;
        if (y < 0) y = 0;
        if (y > h - 1) y = h - 1;
        return y * w + x;
    endfunction

    function automatic logic [107:0] exp_win(input bit sel_b, input int p);
        logic [107:0] w;
        w = '0;
        for (int k = 0; k < 9; k++)
            w[107 - 12 * k -: 12] = sel_b ? mem_b[exp_addr(2, 2, p, k)] : mem_a[exp_addr(4, 3, p, k)];
        return w;
    endfunction

    int a_rd_idx = 0, a_wr_idx = 0, a_first = 0, a_last_wr = 0, a_we_cnt = 0, a_done_cnt = 0;
    int b_rd_idx = 0, b_wr_idx = 0, b_first = 0, b_last_wr = 0, b_done_cnt = 0;
    logic a_busy_p = 1'b0, b_busy_p = 1'b0;

    always @(negedge clk) begin
        if (a_busy && !a_busy_p) a_first = cyc;
        a_busy_p = a_busy;
        if (a_src_rd) begin
            chk("a_rd_busy", 108'(a_busy), 108'(1));
            chk("a_rd_addr", 108'(a_src_addr), 108'(exp_addr(4, 3, a_rd_idx / 9, a_rd_idx % 9)));
            if (a_rd_idx < 108) a_rd_log[a_rd_idx] = int'(a_src_addr);
            a_rd_idx++;
        end
        if (a_dst_we) begin
            chk("a_wr_addr", 108'(a_dst_addr), 108'(a_wr_idx));
            chk("a_rd_count", 108'(a_rd_idx), 108'(9 * (a_wr_idx + 1)));
            chk("a_window", a_color, exp_win(1'b0, a_wr_idx));
            chk("a_wr_data", 108'(a_dst_data), 108'(filt(exp_win(1'b0, a_wr_idx))));
            if (a_wr_idx > 0) chk("a_period", 108'(cyc - a_last_wr), 108'(15));
            a_last_wr = cyc;
            dst_a[a_dst_addr[3:0]] = a_dst_data;
            a_wr_idx++;
            a_we_cnt++;
        end
        if (a_done) begin
            chk("a_done_time", 108'(cyc - a_first), 108'(180));
            chk("a_writes", 108'(a_wr_idx), 108'(12));
            chk("a_done_busy", 108'(a_busy), 108'(0));
            a_done_cnt++;
        end
        if (b_busy && !b_busy_p) b_first = cyc;
        b_busy_p = b_busy;
        if (b_src_rd) begin
            chk("b_rd_addr", 108'(b_src_addr), 108'(exp_addr(2, 2, b_rd_idx / 9, b_rd_idx % 9)));
            b_rd_idx++;
        end
        if (b_dst_we) begin
            chk("b_wr_addr", 108'(b_dst_addr), 108'(b_wr_idx));
            chk("b_rd_count", 108'(b_rd_idx), 108'(9 * (b_wr_idx + 1)));
            chk("b_window", b_color, exp_win(1'b1, b_wr_idx));
            chk("b_wr_data", 108'(b_dst_data), 108'(filt(exp_win(1'b1, b_wr_idx))));
            if (b_wr_idx > 0) chk("b_period", 108'(cyc - b_last_wr), 108'(12));
            b_last_wr = cyc;
            dst_b[b_dst_addr[1:0]] = b_dst_data;
            b_wr_idx++;
        end
        if (b_done) begin
            chk("b_done_time", 108'(cyc - b_first), 108'(48));
            chk("b_writes", 108'(b_wr_idx), 108'(4));
            b_done_cnt++;
        end
    end

    task automatic pulse_a();
        a_rd_idx = 0;
        a_wr_idx = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Runs one frame on A; optionally re-pulses start at cycle restart_at and in the DONE cycle.
    task automatic run_a(input int restart_at, input bit pulse_done);
        int n;
        bit seen;
        @(negedge clk);
        pulse_a();
        n = 1;
        seen = 1'b0;
        while (!seen && n < 400) begin
            if (a_done) begin
                seen = 1'b1;
                start_a = pulse_done;
            end else begin
                start_a = (n == restart_at);
            end
            @(negedge clk);
            n++;
        end
        start_a = 1'b0;
        if (!seen) chk("a_done_timeout", 108'(0), 108'(1));
    endtask

    task automatic chk_a_quiet(input string nm);
        chk({nm, "_src_addr"}, 108'(a_src_addr), 108'(0));
        chk({nm, "_src_rd"}, 108'(a_src_rd), 108'(0));
        chk({nm, "_color"}, a_color, 108'(0));
        chk({nm, "_dst_addr"}, 108'(a_dst_addr), 108'(0));
        chk({nm, "_dst_data"}, 108'(a_dst_data), 108'(0));
        chk({nm, "_dst_we"}, 108'(a_dst_we), 108'(0));
        chk({nm, "_busy"}, 108'(a_busy), 108'(0));
        chk({nm, "_done"}, 108'(a_done), 108'(0));
    endtask

    initial begin
        int n, we_before, done_before;
        bit seen;
        logic [11:0] lit_b [4];
        int lit0 [9];
        int lit11 [9];
        lit0  = '{0, 0, 1, 0, 4, 0, 1, 4, 5};
        lit11 = '{11, 10, 11, 7, 11, 6, 7, 10, 11};
        lit_b = '{12'h123, 12'h456, 12'h789, 12'hABC};
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 12; i++) begin mem_a[i] = 12'(i); dst_a[i] = 12'hBAD; end
        for (int i = 0; i < 4; i++) begin mem_b[i] = lit_b[i]; dst_b[i] = 12'hBAD; end
        repeat (3) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        chk_a_quiet("reset");

        // Pass-through frame: destination mirrors source, window addresses pinned literally.
        run_a(-1, 1'b0);
        for (int i = 0; i < 12; i++) chk("t1_dst", 108'(dst_a[i]), 108'(i));
        for (int k = 0; k < 9; k++) chk("t1_win00", 108'(a_rd_log[k]), 108'(lit0[k]));
        for (int k = 0; k < 9; k++) chk("t1_win32", 108'(a_rd_log[99 + k]), 108'(lit11[k]));

        // Inversion filter on flat frames.
        mode = 1;
        for (int i = 0; i < 12; i++) mem_a[i] = 12'h000;
        run_a(-1, 1'b0);
        for (int i = 0; i < 12; i++) chk("inv_000", 108'(dst_a[i]), 108'(12'hFFF));
        for (int i = 0; i < 12; i++) mem_a[i] = 12'h1A5;
        run_a(-1, 1'b0);
        for (int i = 0; i < 12; i++) chk("inv_1a5", 108'(dst_a[i]), 108'(12'hE5A));

        // Start pulses mid-frame and in the DONE cycle must be ignored.
        mode = 0;
        for (int i = 0; i < 12; i++) mem_a[i] = 12'(i * 37 + 5);
        done_before = a_done_cnt;
        run_a(50, 1'b1);
        repeat (30) @(negedge clk);
        chk("restart_busy", 108'(a_busy), 108'(0));
        chk("restart_done_cnt", 108'(a_done_cnt), 108'(done_before + 1));

        // Asynchronous reset mid-frame.
        pulse_a();
        repeat (36) @(negedge clk);
        #2 rst_a = 1'b0;
        #1 chk_a_quiet("midrst");
        we_before = a_we_cnt;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_no_we", 108'(a_we_cnt), 108'(we_before));
        chk("rst_idle_busy", 108'(a_busy), 108'(0));
        for (int i = 0; i < 12; i++) mem_a[i] = 12'(4095 - i * 11);
        run_a(-1, 1'b0);
        for (int i = 0; i < 12; i++) chk("rst_frame_dst", 108'(dst_a[i]), 108'(4095 - i * 11));

        // Small frame with single-cycle filter.
        b_rd_idx = 0;
        b_wr_idx = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            if (b_done) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!seen) chk("b_done_timeout", 108'(0), 108'(1));
        for (int i = 0; i < 4; i++) chk("b_dst", 108'(dst_b[i]), 108'(lit_b[i]));
        chk("b_done_cnt", 108'(b_done_cnt), 108'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
